ram_burst_reader: RTL and testbench
===================================

Name: ram_burst_reader

Overview:
- Read-side master for the single-port-pair block RAM (2-clk read latency, read data registered in the RAM).
- Accepts a burst command (base address, length) and issues sequential read requests to the RAM.
- Tags returned words and streams them out over a valid/ready interface, with last-beat marking.
- A credit-limited output FIFO absorbs downstream backpressure without losing in-flight RAM data.

Parameters:
- DATA_WIDTH, 10: RAM word width.
- ADDR_WIDTH, 12: RAM address width; addresses wrap modulo 2^ADDR_WIDTH.
- RD_LATENCY, 2: cycles from m_read_req asserted to m_read_data valid. Must be >= 1.
- FIFO_DEPTH, 4: output FIFO entries. Must be >= RD_LATENCY+2 for 1 beat/cycle throughput.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_base_addr  in  ADDR_WIDTH  first word address.
- cmd_len  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH.
- m_read_req  out  1  RAM read strobe, registered.
- m_read_addr  out  ADDR_WIDTH  RAM read address, registered.
- m_read_data  in  DATA_WIDTH  RAM read data.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_WIDTH  output word.
- out_last  out  1  marks the final word of the burst.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- stall_cycles  out  16  backpressure counter (see Optional Feature).

Behaviour:
- Reset values: cmd_ready=1; m_read_req=0, m_read_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, stall_cycles=0. Reset also clears the FIFO, the in-flight pipeline and the FSM.
- FSM states:
  - IDLE: on cmd_valid&&cmd_ready, latch addr/len. len=0 → stay IDLE, pulse done next cycle. len>0 → ISSUE.
  - ISSUE: issue one read per cycle while inflight+fifo_count < FIFO_DEPTH (registered counts, conservative). After len requests → DRAIN.
  - DRAIN: wait until the last-tagged word is handshaken (out_valid&&out_ready&&out_last), then → IDLE; done=1 in the following cycle.
- Request timing:
  - Command accepted in cycle T → first m_read_req=1 in cycle T+1 at base.
  - Address increments by 1 per issued request, wrapping 2^ADDR_WIDTH-1 → 0.
  - m_read_req is never held high without a new address; no duplicate requests.
- In-flight pipeline: RD_LATENCY-deep shift of {valid, last}. An entry exiting the pipeline samples m_read_data into the FIFO in the same cycle. inflight = count of valid pipeline bits.
- Output:
  - FIFO head drives out_data/out_last. out_valid = FIFO not empty.
  - Data is stable while out_valid&&!out_ready.
  - Default timing: first out_valid in cycle T+1+RD_LATENCY+1 = T+4.
- Throughput: with out_ready held high, 1 word/cycle sustained. The credit rule guarantees FIFO never overflows; overflow is a design error (assert in simulation).
- Simultaneous events: FIFO push and pop in one cycle leaves the count unchanged. A new command is not accepted in the cycle the last beat is handshaken; it is accepted from the next cycle (cmd_ready=1 with done=1).
- Reset mid-burst: all state discarded immediately. RAM data returning after reset release is ignored, since the pipeline was cleared.

Optional Feature:
- Macro RAM_BURST_READER_STATS_EN.
  - Defined: stall_cycles increments each cycle out_valid&&!out_ready, saturates at 0xFFFF, clears on command acceptance and on reset.
  - Undefined: stall_cycles tied to 0, no counter logic.

Test Plan:
- Basic burst: base=0x010, len=4, out_ready=1 → m_read_req cycles T+1..T+4, addr 0x010..0x013; out_data = mem[0x010..0x013] on T+4..T+7; out_last on the 4th beat; done at T+8.
- Wrap-around: base=0xFFE, len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001; data order preserved.
- Backpressure: len=8, out_ready=0 for 6 cycles after the first out_valid → at most FIFO_DEPTH words buffered, requests pause, no word lost or duplicated; all 8 words delivered in order once ready returns.
- Zero length: len=0 → no m_read_req, no out_valid, done pulses at T+1, cmd_ready stays 1.
- Reset mid-burst: assert reset during DRAIN of a len=16 burst → all outputs at reset values immediately; a new len=2 burst after release yields exactly 2 correct words.
- Stats (macro defined): out_ready=0 for 5 cycles with out_valid=1 → stall_cycles=5; next command acceptance clears it to 0.

Source files
------------

// File: rtl/ram_burst_reader.sv
// Burst read master for a latency-RD_LATENCY block RAM: issues sequential reads, tags the last beat,
// and streams words out through a credit-limited FIFO. Define RAM_BURST_READER_STATS_EN for stall_cycles.
module ram_burst_reader #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 12,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    output logic                  m_read_req,
    output logic [ADDR_WIDTH-1:0] m_read_addr,
    input  logic [DATA_WIDTH-1:0] m_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           stall_cycles
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int OW = $clog2(FIFO_DEPTH + RD_LATENCY + 2);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic                  req_q;
    logic                  last_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  done_q;

    logic [RD_LATENCY-1:0] pv_q, pl_q;
    logic [DATA_WIDTH-1:0] fdata_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] flast_q;
    logic [PW-1:0]         rd_q, wr_q;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  push, pop, credit_ok;
    logic [OW-1:0]         outstanding;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push      = pv_q[RD_LATENCY-1];
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = fdata_q[rd_q];
    assign out_last  = flast_q[rd_q];
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign m_read_req  = req_q;
    assign m_read_addr = addr_q;

    // Outstanding counts the request on the RAM port too; crediting the
    // concurrent pop keeps 1 word/cycle without ever exceeding FIFO_DEPTH.
    always_comb begin
        outstanding = OW'(cnt_q) + OW'(req_q);
        for (int i = 0; i < RD_LATENCY; i++) outstanding = outstanding + OW'(pv_q[i]);
    end
    assign credit_ok = (outstanding - OW'(pop)) < OW'(FIFO_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            req_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            req_q  <= 1'b0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_q <= 1'b1;
                    end else begin
                        req_q   <= 1'b1;
                        addr_q  <= cmd_base_addr;
                        last_q  <= (cmd_len == (ADDR_WIDTH+1)'(1));
                        rem_q   <= cmd_len - 1'b1;
                        state_q <= (cmd_len == (ADDR_WIDTH+1)'(1)) ? DRAIN : ISSUE;
                    end
                end
                ISSUE: if (credit_ok) begin
                    req_q  <= 1'b1;
                    addr_q <= addr_q + 1'b1;
                    last_q <= (rem_q == (ADDR_WIDTH+1)'(1));
                    rem_q  <= rem_q - 1'b1;
                    if (rem_q == (ADDR_WIDTH+1)'(1)) state_q <= DRAIN;
                end
                DRAIN: if (pop && out_last) begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q    <= '0;
            pl_q    <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            flast_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fdata_q[i] <= '0;
        end else begin
            pv_q[0] <= req_q;
            pl_q[0] <= last_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pl_q[i] <= pl_q[i-1];
            end
            if (push) begin
                fdata_q[wr_q] <= m_read_data;
                flast_q[wr_q] <= pl_q[RD_LATENCY-1];
                wr_q          <= ptr_inc(wr_q);
            end
            if (pop) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        (push && !pop) |-> (cnt_q != CW'(FIFO_DEPTH)));

`ifdef RAM_BURST_READER_STATS_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 stall_q <= '0;
        else if (cmd_ready && cmd_valid)           stall_q <= '0;
        else if (out_valid && !out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader: cycle table for basic/zero-length bursts, then
// scoreboarded runs for wrap, throughput, backpressure, stats and reset mid-burst.
module tb_ram_burst_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_base_addr = '0;
    logic [12:0] cmd_len = '0;
    logic        m_read_req;
    logic [11:0] m_read_addr;
    logic [9:0]  m_read_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [9:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;
    logic [15:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_burst_reader dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base_addr(cmd_base_addr), .cmd_len(cmd_len),
        .m_read_req(m_read_req), .m_read_addr(m_read_addr), .m_read_data(m_read_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .stall_cycles(stall_cycles)
    );

    function automatic logic [9:0] fmem(input logic [11:0] a);
        return a[9:0] ^ {a[11:10], 8'hA5};
    endfunction

    // Two-cycle registered-read RAM; returns filler when not reading.
    logic [9:0] r1 = '0, r2 = '0;
    always @(posedge clk) begin
        r1 <= m_read_req ? fmem(m_read_addr) : 10'h3C3;
        r2 <= r1;
    end
    assign m_read_data = r2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cv;
        logic [11:0] base;
        logic [12:0] len;
        logic        ereq;
        logic [11:0] eaddr;
        logic        evld;
        logic [9:0]  edata;
        logic        elast;
        logic        edone;
        logic        ebusy;
        logic        erdy;
    } vec_t;

    function automatic vec_t mk(logic cv, logic [11:0] base, logic [12:0] len, logic ereq,
                                logic [11:0] eaddr, logic evld, logic [9:0] edata, logic elast,
                                logic edone, logic ebusy, logic erdy);
        vec_t v;
        v.cv = cv; v.base = base; v.len = len; v.ereq = ereq; v.eaddr = eaddr; v.evld = evld;
        v.edata = edata; v.elast = elast; v.edone = edone; v.ebusy = ebusy; v.erdy = erdy;
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_req"}, m_read_req, 0);
        chk({tag, "_addr"}, m_read_addr, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_stall"}, stall_cycles, 0);
    endtask

    // Drives one burst, checks every request address and every presented word against
    // the memory model, bounds outstanding words, and returns at the done pulse.
    task automatic run_burst(input string tag, input logic [11:0] base, input logic [12:0] len,
                             input int stall_n, input int exp_done_cyc, input int exp_stalls);
        int cyc = 0, nreq = 0, nbeat = 0, sc = 0, stalls = 0;
        bit seen = 0, fin = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base_addr = base; cmd_len = len; out_ready = 1'b1;
        while (!fin && cyc < 300) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, "_cmd_ready"}, cmd_ready, 1);
            if (cyc == 1) chk({tag, "_stall_clr"}, stall_cycles, 0);
            if (m_read_req) begin
                chk({tag, "_req_addr"}, m_read_addr, 12'(base + 12'(nreq)));
                nreq++;
                chk({tag, "_outstanding"}, (nreq - nbeat) <= 4, 1);
            end
            if (out_valid) begin
                chk({tag, "_data"}, out_data, fmem(12'(base + 12'(nbeat))));
                chk({tag, "_last"}, out_last, (nbeat == int'(len) - 1));
                if (out_ready) nbeat++;
                else stalls++;
            end
            if (done) begin
                fin = 1;
            end else begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                cyc++;
                if (!seen && out_valid) begin seen = 1; sc = 0; end
                out_ready = !(seen && sc < stall_n);
                if (seen) sc++;
            end
        end
        chk({tag, "_finished"}, fin, 1);
        chk({tag, "_nreq"}, nreq, len);
        chk({tag, "_nbeat"}, nbeat, len);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_done_rdy"}, cmd_ready, 1);
        chk({tag, "_stalls_seen"}, stalls, exp_stalls);
        if (exp_done_cyc >= 0) chk({tag, "_done_cyc"}, cyc, exp_done_cyc);
`ifdef RAM_BURST_READER_STATS_EN
        chk({tag, "_stall_cycles"}, stall_cycles, exp_stalls);
`else
        chk({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
        cmd_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[11];
        int nreq;
        tbl[0]  = mk(1, 12'h010, 13'd4, 0, 12'h000, 0, 10'h0,         0, 0, 0, 1);
        tbl[1]  = mk(0, 12'h010, 13'd4, 1, 12'h010, 0, 10'h0,         0, 0, 1, 0);
        tbl[2]  = mk(0, 12'h010, 13'd4, 1, 12'h011, 0, 10'h0,         0, 0, 1, 0);
        tbl[3]  = mk(0, 12'h010, 13'd4, 1, 12'h012, 0, 10'h0,         0, 0, 1, 0);
        tbl[4]  = mk(0, 12'h010, 13'd4, 1, 12'h013, 1, fmem(12'h010), 0, 0, 1, 0);
        tbl[5]  = mk(0, 12'h010, 13'd4, 0, 12'h000, 1, fmem(12'h011), 0, 0, 1, 0);
        tbl[6]  = mk(0, 12'h010, 13'd4, 0, 12'h000, 1, fmem(12'h012), 0, 0, 1, 0);
        tbl[7]  = mk(0, 12'h010, 13'd4, 0, 12'h000, 1, fmem(12'h013), 1, 0, 1, 0);
        tbl[8]  = mk(1, 12'h123, 13'd0, 0, 12'h000, 0, 10'h0,         0, 1, 0, 1);
        tbl[9]  = mk(0, 12'h123, 13'd0, 0, 12'h000, 0, 10'h0,         0, 1, 0, 1);
        tbl[10] = mk(0, 12'h123, 13'd0, 0, 12'h000, 0, 10'h0,         0, 0, 0, 1);

        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            cmd_valid = tbl[i].cv; cmd_base_addr = tbl[i].base; cmd_len = tbl[i].len;
            @(negedge clk);
            chk($sformatf("row%0d_req", i), m_read_req, tbl[i].ereq);
            if (tbl[i].ereq) chk($sformatf("row%0d_addr", i), m_read_addr, tbl[i].eaddr);
            chk($sformatf("row%0d_valid", i), out_valid, tbl[i].evld);
            if (tbl[i].evld) begin
                chk($sformatf("row%0d_data", i), out_data, tbl[i].edata);
                chk($sformatf("row%0d_last", i), out_last, tbl[i].elast);
            end
            chk($sformatf("row%0d_done", i), done, tbl[i].edone);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].ebusy);
            chk($sformatf("row%0d_cmd_ready", i), cmd_ready, tbl[i].erdy);
        end
        cmd_valid = 1'b0;

        run_burst("wrap", 12'hFFE, 13'd4, 0, 8, 0);
        run_burst("thru", 12'h200, 13'd8, 0, 12, 0);
        run_burst("bp", 12'h020, 13'd8, 6, -1, 6);
        run_burst("stats", 12'h300, 13'd6, 5, -1, 5);

        // Reset while draining a 16-word burst, then confirm a clean 2-word burst.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_base_addr = 12'h400; cmd_len = 13'd16; out_ready = 1'b1;
        nreq = 0;
        for (int c = 0; c < 100 && nreq < 16; c++) begin
            @(negedge clk);
            if (m_read_req) nreq++;
            if (nreq < 16) begin @(posedge clk); #1; cmd_valid = 1'b0; end
        end
        cmd_valid = 1'b0;
        chk("rst_mid_reached_drain", nreq, 16);
        chk("rst_mid_busy_before", busy, 1);
        reset = 1'b1;
        #1 check_reset_outputs("rst_mid");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        run_burst("post_rst", 12'h100, 13'd2, 0, 6, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_extra", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
